// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg
// Shared configuration for the L1 instruction-cache refill path. The user
// configuration record is the single source of truth; every width used by
// the refill controller and its victim selector is derived from it here.
// Contents:
//   user_cfg_t       raw cache/bus configuration
//   derived widths   OFF_W, IDX_W, WAY_W, TAG_W, NUM_SETS, BEATS, BEAT_W
//   refill_state_e   refill sequencer states
//   icache_refill_t  one tag/data array write (set, way, tag, line)
package icache_refill_ctrl_pkg;

  typedef struct packed {
    int unsigned xlen;
    int unsigned byte_size;
    int unsigned set_assoc;
    int unsigned line_width;
    int unsigned mem_dw;
  } user_cfg_t;

  localparam user_cfg_t ICACHE_CFG = '{
    xlen:       32,
    byte_size:  4096,
    set_assoc:  4,
    line_width: 256,
    mem_dw:     32
  };

  localparam int XLEN              = int'(ICACHE_CFG.xlen);
  localparam int ICACHE_BYTE_SIZE  = int'(ICACHE_CFG.byte_size);
  localparam int ICACHE_SET_ASSOC  = int'(ICACHE_CFG.set_assoc);
  localparam int ICACHE_LINE_WIDTH = int'(ICACHE_CFG.line_width);
  localparam int MEM_DW            = int'(ICACHE_CFG.mem_dw);

  localparam int LINE_BYTES = ICACHE_LINE_WIDTH / 8;
  localparam int NUM_SETS   = ICACHE_BYTE_SIZE / (ICACHE_SET_ASSOC * LINE_BYTES);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(NUM_SETS);
  localparam int WAY_W      = $clog2(ICACHE_SET_ASSOC);
  localparam int TAG_W      = XLEN - IDX_W - OFF_W;
  localparam int BEATS      = ICACHE_LINE_WIDTH / MEM_DW;
  localparam int BEAT_W     = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_WRITE,
    ST_DRAIN
  } refill_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]             set_idx;
    logic [WAY_W-1:0]             way;
    logic [TAG_W-1:0]             tag;
    logic [ICACHE_LINE_WIDTH-1:0] line;
  } icache_refill_t;

  // Rebuild the line-aligned byte address from the latched tag and set.
  function automatic logic [XLEN-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                input logic [IDX_W-1:0] set_idx);
    return {tag, set_idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_victim_rr.sv
// icache_victim_rr
// Per-set round-robin victim selector. Holds one WAY_W pointer per set; the
// pointer of a set names the way that the next refill of that set replaces.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (all pointers to 0)
//   clear      zero every pointer (cache flush)
//   inc        advance the pointer of inc_set by one, wrapping at SET_ASSOC
//   inc_set    set whose pointer advances
//   rd_set     set being looked up
//   rd_way     current victim way of rd_set
module icache_victim_rr
  import icache_refill_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_set,
  input  logic [IDX_W-1:0] rd_set,
  output logic [WAY_W-1:0] rd_way
);

  logic [WAY_W-1:0] ptr [NUM_SETS];

  // Clear has priority so a flush landing on a refill write leaves every
  // pointer at zero. SET_ASSOC is a power of two, so the natural WAY_W-bit
  // wrap of the increment is the modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) ptr[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SETS; i++) ptr[i] <= '0;
    end else if (inc) begin
      ptr[inc_set] <= ptr[inc_set] + WAY_W'(1);
    end
  end

  assign rd_way = ptr[rd_set];

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Miss-refill sequencer for the L1 instruction cache. Accepts one line miss,
// issues a single line-aligned read, gathers BEATS response beats into a
// line buffer and writes the line into the way chosen by the per-set
// round-robin victim selector. Bus errors turn the write into a one-cycle
// refill_err_o pulse; a flush aborts the refill quietly while still
// finishing the bus transaction.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             abort any refill in flight, clear victim pointers
//   miss_*              miss request handshake (ready only when idle)
//   mem_req_*           line read request to memory
//   mem_rsp_*           response beats (data + bus error flag)
//   refill_we_o         one-cycle array write strobe with set/way/tag/line
//   refill_err_o        one-cycle pulse: refill failed, nothing written
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         miss_valid_i,
  input  logic [XLEN-1:0]              miss_addr_i,
  output logic                         miss_ready_o,
  output logic                         mem_req_valid_o,
  output logic [XLEN-1:0]              mem_req_addr_o,
  input  logic                         mem_req_ready_i,
  input  logic                         mem_rsp_valid_i,
  input  logic [MEM_DW-1:0]            mem_rsp_data_i,
  input  logic                         mem_rsp_err_i,
  output logic                         mem_rsp_ready_o,
  output logic                         refill_we_o,
  output logic [IDX_W-1:0]             refill_set_o,
  output logic [WAY_W-1:0]             refill_way_o,
  output logic [TAG_W-1:0]             refill_tag_o,
  output logic [ICACHE_LINE_WIDTH-1:0] refill_line_o,
  output logic                         refill_err_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  refill_state_e state_q, state_d;

  logic [BEAT_W-1:0]            beat_cnt;
  logic [TAG_W-1:0]             tag_q;
  logic [IDX_W-1:0]             set_q;
  logic [ICACHE_LINE_WIDTH-1:0] line_q;
  logic                         err_q;
  logic                         abort_q;
  logic                         err_pulse_q;

  logic           miss_fire;
  logic           req_fire;
  logic           beat_fire;
  logic           last_beat;
  logic           beat_err;
  logic           write_en;
  logic [WAY_W-1:0] victim_way;
  icache_refill_t wr_pkt;
  logic           unused_addr_bits;

  // The byte offset inside the line is irrelevant: refills are whole lines.
  assign unused_addr_bits = ^miss_addr_i[OFF_W-1:0];

  assign miss_fire = miss_valid_i & miss_ready_o;
  assign req_fire  = mem_req_valid_o & mem_req_ready_i;
  assign beat_fire = mem_rsp_valid_i & mem_rsp_ready_o;
  assign last_beat = beat_fire & (beat_cnt == LAST_BEAT);
  // Sticky error including the beat being accepted this cycle.
  assign beat_err  = err_q | mem_rsp_err_i;
  // A flush arriving in the write cycle cancels the write outright.
  assign write_en  = (state_q == ST_WRITE) & ~flush_i;

  assign wr_pkt = '{set_idx: set_q, way: victim_way, tag: tag_q, line: line_q};

  icache_victim_rr u_victim (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (flush_i),
    .inc     (write_en),
    .inc_set (set_q),
    .rd_set  (set_q),
    .rd_way  (victim_way)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. DRAIN covers every aborted refill once the request
  // has been accepted: it keeps taking beats until the last one and then
  // returns to IDLE without writing or reporting an error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_fire) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_fire) state_d = (abort_q | flush_i) ? ST_DRAIN : ST_RECV;
      end
      ST_RECV: begin
        if (last_beat) begin
          if (flush_i | beat_err) state_d = ST_IDLE;
          else                    state_d = ST_WRITE;
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_beat) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. Everything not owned by the current state is held at
  // zero so the interfaces read clean while idle or in reset.
  always_comb begin
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_rsp_ready_o = 1'b0;
    refill_we_o     = 1'b0;
    refill_set_o    = '0;
    refill_way_o    = '0;
    refill_tag_o    = '0;
    refill_line_o   = '0;
    refill_err_o    = err_pulse_q;
    unique case (state_q)
      ST_IDLE: begin
        miss_ready_o = 1'b1;
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = line_addr(tag_q, set_q);
      end
      ST_RECV, ST_DRAIN: begin
        mem_rsp_ready_o = 1'b1;
      end
      ST_WRITE: begin
        if (write_en) begin
          refill_we_o   = 1'b1;
          refill_set_o  = wr_pkt.set_idx;
          refill_way_o  = wr_pkt.way;
          refill_tag_o  = wr_pkt.tag;
          refill_line_o = wr_pkt.line;
        end
      end
      default: ;
    endcase
  end

  // Refill datapath: miss address latch, beat counter, line buffer and the
  // error/abort bookkeeping. The error pulse is registered so it lands in
  // the cycle after the last beat, the same slot a successful write uses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt    <= '0;
      tag_q       <= '0;
      set_q       <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= (state_q == ST_RECV) & last_beat & ~flush_i & beat_err;

      if (miss_fire) begin
        tag_q <= miss_addr_i[XLEN-1 -: TAG_W];
        set_q <= miss_addr_i[OFF_W +: IDX_W];
      end

      if (state_q == ST_IDLE) begin
        beat_cnt <= '0;
        err_q    <= 1'b0;
        abort_q  <= 1'b0;
      end

      if ((state_q == ST_REQ) && flush_i) abort_q <= 1'b1;

      if (beat_fire) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        err_q    <= beat_err;
        if (state_q == ST_RECV) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == BEAT_W'(k)) line_q[k*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl
// Scoreboard bench for icache_refill_ctrl. The driver issues misses and plays
// the memory side; for each miss a cache-level model (per-set victim counters,
// flush/error outcome rules) pushes the expected request address and the
// expected array event into queues. A negedge monitor pops and compares
// whenever the DUT shows a request, a write or an error pulse.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         mem_rsp_err;
  logic         mem_rsp_ready;
  logic         refill_we;
  logic [4:0]   refill_set;
  logic [1:0]   refill_way;
  logic [21:0]  refill_tag;
  logic [255:0] refill_line;
  logic         refill_err;

  icache_refill_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .miss_valid_i    (miss_valid),
    .miss_addr_i     (miss_addr),
    .miss_ready_o    (miss_ready),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_ready_i (mem_req_ready),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .mem_rsp_err_i   (mem_rsp_err),
    .mem_rsp_ready_o (mem_rsp_ready),
    .refill_we_o     (refill_we),
    .refill_set_o    (refill_set),
    .refill_way_o    (refill_way),
    .refill_tag_o    (refill_tag),
    .refill_line_o   (refill_line),
    .refill_err_o    (refill_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    int           set;
    int           way;
    logic [21:0]  tag;
    logic [255:0] line;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int          ptr[32];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;
  int unsigned last_we_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [21:0] tag, input logic [4:0] set, input logic [4:0] off);
    return {tag, set, off};
  endfunction

  // Cache-level model. flush_at: -1 none, 0..7 with beat k, 8 in the request
  // phase, 9 in the cycle after the last beat, 10 together with the miss.
  task automatic model_issue(input logic [31:0] addr, input int err_beat, input int flush_at,
                             input logic [255:0] line);
    exp_t        e;
    logic [31:0] t;
    int          set;
    set = int'((addr / 32) % 32);
    t   = addr / 1024;
    req_q.push_back(addr - (addr % 32));
    if (flush_at == 10) foreach (ptr[i]) ptr[i] = 0;
    e.set = set; e.tag = t[21:0]; e.line = line; e.way = 0; e.is_err = 0;
    if (flush_at >= 0 && flush_at <= 8) begin
      foreach (ptr[i]) ptr[i] = 0;
    end else if (err_beat >= 0) begin
      e.is_err = 1;
      exp_q.push_back(e);
      if (flush_at == 9) foreach (ptr[i]) ptr[i] = 0;
    end else if (flush_at == 9) begin
      foreach (ptr[i]) ptr[i] = 0;
    end else begin
      e.way = ptr[set];
      exp_q.push_back(e);
      ptr[set] = (ptr[set] + 1) % 4;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!miss_ready && n < 50) begin step(); n++; end
    check_output("miss_ready_idle", miss_ready, 1);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input int req_wait, input int gap_pct,
                                input int err_beat, input int flush_at, input bit pattern);
    logic [31:0]  beats[8];
    logic [255:0] line;
    int           k;
    int           guard;
    int           n;
    for (int i = 0; i < 8; i++) begin
      beats[i] = pattern ? 32'h11111111 * i : $urandom;
      line[i*32 +: 32] = beats[i];
    end
    model_issue(addr, err_beat, flush_at, line);
    wait_idle();
    accept_cyc = cyc;
    miss_valid = 1'b1;
    miss_addr  = addr;
    flush      = (flush_at == 10);
    step();
    miss_valid = 1'b0;
    flush      = 1'b0;
    miss_addr  = $urandom;
    n = 0;
    while (!mem_req_valid && n < 20) begin step(); n++; end
    check_output("req_valid", mem_req_valid, 1);
    for (int i = 0; i < req_wait; i++) begin
      if (i == 0) check_output("no_beats_before_req", mem_rsp_ready, 0);
      flush = (flush_at == 8 && i == 0);
      step();
    end
    flush = (flush_at == 8 && req_wait == 0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    flush = 1'b0;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        mem_rsp_valid = 1'b0;
        step();
      end else begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beats[k];
        mem_rsp_err   = (k == err_beat);
        flush         = (k == flush_at);
        check_output("rsp_ready", mem_rsp_ready, 1);
        step();
        k++;
      end
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_data  = '0;
    flush         = (flush_at == 9);
    step();
    flush = 1'b0;
  endtask

  // Asynchronous reset in the middle of the beat stream.
  task automatic reset_mid_recv(input logic [31:0] addr);
    req_q.push_back(addr - (addr % 32));
    foreach (ptr[i]) ptr[i] = 0;
    wait_idle();
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      step();
    end
    #2;
    rst = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    check_output("rst_mid_miss_ready", miss_ready, 1);
    check_output("rst_mid_rsp_ready", mem_rsp_ready, 0);
    check_output("rst_mid_req_valid", mem_req_valid, 0);
    check_output("rst_mid_we", refill_we, 0);
    check_output("rst_mid_err", refill_err, 0);
    #3;
    rst = 1'b0;
    step();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL req_unexpected: got addr %0h required no request", mem_req_addr);
        end else begin
          check_output("req_addr", mem_req_addr, req_q[0]);
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (refill_we || refill_err) begin
        check_output("we_err_exclusive", refill_we & refill_err, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL event_unexpected: got we=%0b err=%0b required none", refill_we, refill_err);
        end else begin
          e = exp_q.pop_front();
          check_output("event_kind", refill_err, e.is_err);
          if (!e.is_err && refill_we) begin
            check_output("refill_set", refill_set, e.set);
            check_output("refill_way", refill_way, e.way);
            check_output("refill_tag", refill_tag, e.tag);
            check_output("refill_line", refill_line, e.line);
          end
        end
        if (refill_we) last_we_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int set_sel;
    logic [4:0] set;
    int err_beat;
    int flush_at;
    rst = 1'b1; flush = 1'b0; miss_valid = 1'b0; miss_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    foreach (ptr[i]) ptr[i] = 0;
    #12;
    check_output("reset_miss_ready", miss_ready, 1);
    check_output("reset_req_valid", mem_req_valid, 0);
    check_output("reset_req_addr", mem_req_addr, 0);
    check_output("reset_rsp_ready", mem_rsp_ready, 0);
    check_output("reset_we", refill_we, 0);
    check_output("reset_err", refill_err, 0);
    check_output("reset_line", refill_line, 0);
    #10;
    rst = 1'b0;
    step();

    $display("[TB] zero-wait refill");
    apply_stimulus(32'h8000_1234, 0, 0, -1, -1, 1'b1);
    check_output("miss_to_write_latency", last_we_cyc - accept_cyc, 10);

    $display("[TB] round-robin in set 0x11");
    for (int i = 0; i < 4; i++) apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h03, 5'($urandom)), 0, 0, -1, -1, 1'b0);

    $display("[TB] request backpressure and beat gaps");
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 5, 0, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(mk_addr(22'($urandom), 5'h07, 5'($urandom)), 0, 40, -1, -1, 1'b0);

    $display("[TB] bus error and flush cases");
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 20, 3, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, 4, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 3, 0, -1, 8, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, 8, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, 9, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, 10, 1'b0);

    $display("[TB] reset during beats");
    reset_mid_recv(mk_addr(22'($urandom), 5'h11, 5'($urandom)));
    apply_stimulus(mk_addr(22'($urandom), 5'h11, 5'($urandom)), 0, 0, -1, -1, 1'b0);

    $display("[TB] randomized refills");
    for (int i = 0; i < 60; i++) begin
      set_sel  = $urandom_range(3);
      set      = (set_sel == 0) ? 5'h11 : (set_sel == 1) ? 5'h05 : 5'($urandom);
      err_beat = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
      flush_at = ($urandom_range(7) == 0) ? int'($urandom_range(10)) : -1;
      apply_stimulus(mk_addr(22'($urandom), set, 5'($urandom)),
                     ($urandom_range(9) == 0) ? 6 : int'($urandom_range(3)),
                     int'($urandom_range(50)), err_beat, flush_at, 1'b0);
    end

    step(); step();
    check_output("exp_queue_drained", exp_q.size(), 0);
    check_output("req_queue_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
